// File: rtl/load_store_unit.sv
// load_store_unit: sub-word load/store sequencer between the multicycle
// datapath and a 32-bit word-only memory. It performs RV32I LB/LH/LW/LBU/LHU
// loads with sign or zero extension, and SB/SH/SW stores using
// read-modify-write where needed.
// Optional build macro: MISALIGN_TRAP_EN. When it is defined, misaligned
// half/word accesses are trapped instead of being silently aligned.
module load_store_unit #(
  parameter int XLEN     = 32,
  parameter int ADDR_LSB = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic            we,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  output logic            done,
  output logic            busy,
  output logic            misalign,
  output logic [XLEN-1:0] mem_a,
  output logic [XLEN-1:0] mem_wd,
  output logic            mem_we,
  input  logic [XLEN-1:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t         state;
  logic [1:0]     off_q;
  logic [2:0]     funct3_q;
  logic [XLEN-1:0] wdata_q;
  logic           we_q;
  logic           misalign_q;
  logic           trap;

  // funct3[1:0] == 2'b1x (including undefined codes) is treated as a word access.
  function automatic logic is_word(input logic [2:0] f3);
    return f3[1];
  endfunction

  function automatic logic is_half(input logic [2:0] f3);
    return (f3[1:0] == 2'b01);
  endfunction

  // Select the addressed byte or halfword lane, then sign- or zero-extend it.
  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] w,
                                              input logic [2:0] f3,
                                              input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3[1:0])
      2'b00:   extract = f3[2] ? {{(XLEN-8){1'b0}}, b}  : {{(XLEN-8){b[7]}}, b};
      2'b01:   extract = f3[2] ? {{(XLEN-16){1'b0}}, h} : {{(XLEN-16){h[15]}}, h};
      default: extract = w;
    endcase
  endfunction

  // Overwrite only the addressed lane of the old word; all other lanes are kept.
  function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] w,
                                            input logic [XLEN-1:0] wd,
                                            input logic [2:0] f3,
                                            input logic [1:0] off);
    logic [XLEN-1:0] r;
    r = w;
    case (f3[1:0])
      2'b00: r[{off, 3'b000} +: 8] = wd[7:0];
      2'b01: if (off[1]) r[31:16] = wd[15:0];
             else        r[15:0]  = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  // Decide at capture time whether the request is a trapped misaligned access.
`ifdef MISALIGN_TRAP_EN
  assign trap = (is_half(funct3) && addr[0]) || (is_word(funct3) && (addr[1:0] != 2'b00));
  assign misalign = misalign_q;
`else
  assign trap = 1'b0;
  assign misalign = 1'b0;
`endif

  // Access sequencer. All outputs are registered.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rdata      <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      misalign_q <= 1'b0;
      mem_we     <= 1'b0;
      mem_wd     <= '0;
      mem_a      <= '0;
      off_q      <= '0;
      funct3_q   <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
    end else begin
      done       <= 1'b0;
      mem_we     <= 1'b0;
      misalign_q <= 1'b0;
      case (state)
        IDLE: if (req) begin
          off_q    <= addr[1:0];
          funct3_q <= funct3;
          wdata_q  <= wdata;
          we_q     <= we;
          mem_a    <= {addr[XLEN-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
          busy     <= 1'b1;
          if (trap) begin
            state      <= DONE;
            done       <= 1'b1;
            misalign_q <= 1'b1;
          end else if (we && is_word(funct3)) begin
            state  <= WRITE;
            mem_we <= 1'b1;
            mem_wd <= wdata;
          end else begin
            state <= READ;
          end
        end
        READ: begin
          if (!we_q) begin
            rdata <= extract(mem_rd, funct3_q, off_q);
            state <= DONE;
            done  <= 1'b1;
          end else begin
            mem_wd <= merge(mem_rd, wdata_q, funct3_q, off_q);
            mem_we <= 1'b1;
            state  <= WRITE;
          end
        end
        WRITE: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed-vector bench for load_store_unit with a small
// word memory model. Expected values are hand-computed constants.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        busy;
  logic        misalign;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:63];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_val;

  int n_vec  = 0;
  int n_fail = 0;

  load_store_unit dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .busy(busy),
    .misalign(misalign), .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we),
    .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Word memory: combinational read, write on the rising edge.
  assign mem_rd = mem[mem_a[7:2]];
  always @(posedge clk) begin
    if (pl_en)       mem[pl_idx] <= pl_val;
    else if (mem_we) mem[mem_a[7:2]] <= mem_wd;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // One access: lat counts edges from the capture edge to done observed high.
  task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output int wes,
                        output logic mis);
    @(negedge clk);
    req = 1'b1; we = st; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 1; wes = 0;
    while (!done && lat < 10) begin
      wes += int'(mem_we);
      @(posedge clk); #1;
      lat++;
    end
    check("done_seen", {31'b0, done}, 32'd1);
    wes += int'(mem_we);
    mis = misalign;
    @(posedge clk); #1;
    check("done_one_cycle", {31'b0, done}, 32'd0);
  endtask

  initial begin
    int lat, wes;
    logic mis;
    rst = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'b0; addr = '0; wdata = '0;
    pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_flags", {27'b0, done, busy, misalign, mem_we, 1'b0}, 32'h0);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_wd", mem_wd, 32'h0);
    rst = 1'b0;

    preload(6'd4, 32'h80FF7F01);

    access(1'b0, 3'b000, 32'h13, 32'h0, lat, wes, mis);
    check("lb_rdata", rdata, 32'hFFFFFF80);
    check("lb_lat", lat, 32'd2);
    access(1'b0, 3'b100, 32'h13, 32'h0, lat, wes, mis);
    check("lbu_rdata", rdata, 32'h00000080);
    access(1'b0, 3'b001, 32'h12, 32'h0, lat, wes, mis);
    check("lh_rdata", rdata, 32'hFFFF80FF);
    access(1'b0, 3'b101, 32'h10, 32'h0, lat, wes, mis);
    check("lhu_rdata", rdata, 32'h00007F01);
    access(1'b0, 3'b010, 32'h10, 32'h0, lat, wes, mis);
    check("lw_rdata", rdata, 32'h80FF7F01);
    check("lw_lat", lat, 32'd2);
    check("lw_no_write", wes, 32'd0);

    // Reload a different rdata first, so the LH at off=3 must change it.
    access(1'b0, 3'b100, 32'h10, 32'h0, lat, wes, mis);
    check("lbu0_rdata", rdata, 32'h00000001);
    access(1'b0, 3'b001, 32'h13, 32'h0, lat, wes, mis);
`ifdef MISALIGN_TRAP_EN
    check("lh_off3_rdata", rdata, 32'h00000001);
    check("lh_off3_mis", {31'b0, mis}, 32'd1);
    check("lh_off3_lat", lat, 32'd1);
`else
    check("lh_off3_rdata", rdata, 32'hFFFF80FF);
    check("lh_off3_mis", {31'b0, mis}, 32'd0);
`endif
    access(1'b0, 3'b011, 32'h10, 32'h0, lat, wes, mis);
    check("undef_f3_rdata", rdata, 32'h80FF7F01);

    access(1'b1, 3'b000, 32'h11, 32'h000000AA, lat, wes, mis);
    check("sb_mem", mem[4], 32'h80FFAA01);
    check("sb_we_cycles", wes, 32'd1);
    check("sb_lat", lat, 32'd3);
    check("sb_rdata_held", rdata, 32'h80FF7F01);

    preload(6'd4, 32'h80FF7F01);
    access(1'b1, 3'b001, 32'h12, 32'h00001234, lat, wes, mis);
    check("sh_mem", mem[4], 32'h12347F01);
    check("sh_lat", lat, 32'd3);
    access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, wes, mis);
    check("sw_mem", mem[4], 32'hDEADBEEF);
    check("sw_lat", lat, 32'd2);
    check("sw_we_cycles", wes, 32'd1);

    // Reset asserted while the SB is in READ aborts it without a write.
    preload(6'd4, 32'h11223344);
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 32'h10; wdata = 32'hFF;
    @(posedge clk); #1;
    req = 1'b0;
    check("mid_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_flags", {27'b0, done, busy, misalign, mem_we, 1'b0}, 32'h0);
    check("mid_mem_a", mem_a, 32'h0);
    check("mid_rdata", rdata, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("mid_mem", mem[4], 32'h11223344);
    check("mid_idle", {31'b0, busy}, 32'd0);

    // req held high through the whole access: only one store happens.
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 32'h12; wdata = 32'h55;
    wes = 0; lat = 0;
    while (!done && lat < 10) begin
      @(posedge clk); #1;
      wes += int'(mem_we);
      lat++;
    end
    req = 1'b0;
    check("hold_done_seen", {31'b0, done}, 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      wes += int'(mem_we);
    end
    check("hold_we_cycles", wes, 32'd1);
    check("hold_mem", mem[4], 32'h11553344);
    check("hold_idle", {31'b0, busy}, 32'd0);

    access(1'b1, 3'b010, 32'h11, 32'hCAFEF00D, lat, wes, mis);
`ifdef MISALIGN_TRAP_EN
    check("sw_mis_flag", {31'b0, mis}, 32'd1);
    check("sw_mis_lat", lat, 32'd1);
    check("sw_mis_we", wes, 32'd0);
    check("sw_mis_mem", mem[4], 32'h11553344);
`else
    check("sw_mis_flag", {31'b0, mis}, 32'd0);
    check("sw_mis_lat", lat, 32'd2);
    check("sw_mis_we", wes, 32'd1);
    check("sw_mis_mem", mem[4], 32'hCAFEF00D);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
